// File: rtl/whack_pkg.sv
// Shared types and sizes for the whack-a-mole game controller and its score accumulator.
package whack_pkg;

  localparam int unsigned MOLE_CNT      = 8;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned SCORE_DIGITS  = 4;
  localparam int unsigned SCORE_W       = 4 * SCORE_DIGITS;
  localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_SEL = 3'd2,
    ST_SHOW     = 3'd3,
    ST_NEXT     = 3'd4,
    ST_OVER     = 3'd5
  } state_t;

endpackage

// File: rtl/bcd_score_acc.sv
// 4-digit BCD score register: clear, add a single digit (saturating at 9999), decrement by one (floored at 0).
module bcd_score_acc
  import whack_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_add,
  input  logic [3:0]         i_add_digit,
  input  logic               i_dec,
  output logic [SCORE_W-1:0] o_score
);

  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_sum;
  logic [SCORE_W-1:0] w_diff;
  logic               w_add_ovf;

  // Ripple decimal carry from the units digit upward.
  always_comb begin : p_add
    logic [4:0] v_d;
    logic [4:0] v_c;
    w_sum = '0;
    v_d   = '0;
    v_c   = 5'(i_add_digit);
    for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
      v_d = 5'(r_score[4*i +: 4]) + v_c;
      if (v_d > 5'd9) begin
        w_sum[4*i +: 4] = 4'(v_d - 5'd10);
        v_c             = 5'd1;
      end else begin
        w_sum[4*i +: 4] = v_d[3:0];
        v_c             = 5'd0;
      end
    end
    w_add_ovf = (v_c != 5'd0);
  end

  // Ripple decimal borrow; only used when the score is non-zero.
  always_comb begin : p_dec
    logic v_b;
    w_diff = '0;
    v_b    = 1'b1;
    for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
      if (v_b && (r_score[4*i +: 4] == 4'd0)) begin
        w_diff[4*i +: 4] = 4'd9;
      end else if (v_b) begin
        w_diff[4*i +: 4] = r_score[4*i +: 4] - 4'd1;
        v_b              = 1'b0;
      end else begin
        w_diff[4*i +: 4] = r_score[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= '0;
    end else if (i_clr) begin
      r_score <= '0;
    end else if (i_add) begin
      r_score <= w_add_ovf ? SCORE_MAX_BCD : w_sum;
    end else if (i_dec && (r_score != '0)) begin
      r_score <= w_diff;
    end
  end

  assign o_score = r_score;

endmodule

// File: rtl/whack_game_ctrl.sv
// Round-sequencing controller for the whack-a-mole game.
// Define WHACK_MISS_PENALTY_EN to charge one point for wrong-mole releases during a round.
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int unsigned SCORE_MULT = 1
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_pulse,
  input  logic [MOLE_CNT-1:0] mole_release,
  input  logic                round_timeout,
  input  logic [SEL_W-1:0]    sel_number,
  input  logic                sel_done,
  input  logic                sel_all_selected,
  output logic                sel_req,
  output logic                round_start,
  output logic [MOLE_CNT-1:0] mole_pattern,
  output logic [SCORE_W-1:0]  score,
  output logic                hit_event,
  output logic                game_over
);

  localparam logic [3:0] ADD_DIGIT = 4'(SCORE_MULT);

  state_t              r_state;
  logic [SEL_W-1:0]    r_target;
  logic [MOLE_CNT-1:0] r_mole_pattern;
  logic                r_sel_req;
  logic                r_round_start;
  logic                r_hit_event;
  logic                r_game_over;

  logic w_hit;
  logic w_clr;
  logic w_dec;

  assign w_hit = (r_state == ST_SHOW) && mole_release[r_target];
  assign w_clr = start_pulse && ((r_state == ST_IDLE) || (r_state == ST_OVER));

`ifdef WHACK_MISS_PENALTY_EN
  // While showing, the pattern is exactly the target bit, so anything else released is a wrong mole.
  logic [MOLE_CNT-1:0] w_wrong;
  assign w_wrong = mole_release & ~r_mole_pattern;
  assign w_dec   = (r_state == ST_SHOW) && !w_hit && (w_wrong != '0);
`else
  assign w_dec   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_target       <= '0;
      r_mole_pattern <= '0;
      r_sel_req      <= 1'b0;
      r_round_start  <= 1'b0;
      r_hit_event    <= 1'b0;
      r_game_over    <= 1'b0;
    end else begin
      r_sel_req     <= 1'b0;
      r_round_start <= 1'b0;
      r_hit_event   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_pulse) begin
            r_sel_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_state <= ST_WAIT_SEL;
        end
        ST_WAIT_SEL: begin
          if (sel_done) begin
            r_target       <= sel_number;
            r_mole_pattern <= MOLE_CNT'(1) << sel_number;
            r_round_start  <= 1'b1;
            r_state        <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (w_hit) begin
            r_hit_event    <= 1'b1;
            r_mole_pattern <= '0;
            r_state        <= ST_NEXT;
          end else if (round_timeout) begin
            r_mole_pattern <= '0;
            r_state        <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (sel_all_selected) begin
            r_game_over <= 1'b1;
            r_state     <= ST_OVER;
          end else begin
            r_sel_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_OVER: begin
          if (start_pulse) begin
            r_game_over <= 1'b0;
            r_sel_req   <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  bcd_score_acc u_score (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_clr),
    .i_add       (w_hit),
    .i_add_digit (ADD_DIGIT),
    .i_dec       (w_dec),
    .o_score     (score)
  );

  assign sel_req      = r_sel_req;
  assign round_start  = r_round_start;
  assign mole_pattern = r_mole_pattern;
  assign hit_event    = r_hit_event;
  assign game_over    = r_game_over;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Randomized bench for whack_game_ctrl against an integer-score game model with a mock unique selector.
module tb_whack_game_ctrl;

  localparam int MULT = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_pulse;
  logic [7:0] mole_release;
  logic       round_timeout;
  logic [2:0] sel_number;
  logic       sel_done;
  logic       sel_all_selected;
  logic       sel_req;
  logic       round_start;
  logic [7:0] mole_pattern;
  logic [15:0] score;
  logic       hit_event;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_score;
  bit [7:0] pool;
  bit long_mode;
  int long_left;

  always #5 clk = ~clk;

  whack_game_ctrl #(.SCORE_MULT(MULT)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_pulse      (start_pulse),
    .mole_release     (mole_release),
    .round_timeout    (round_timeout),
    .sel_number       (sel_number),
    .sel_done         (sel_done),
    .sel_all_selected (sel_all_selected),
    .sel_req          (sel_req),
    .round_start      (round_start),
    .mole_pattern     (mole_pattern),
    .score            (score),
    .hit_event        (hit_event),
    .game_over        (game_over)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    start_pulse   = 1'b0;
    mole_release  = '0;
    round_timeout = 1'b0;
    sel_done      = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel_req"},   32'(sel_req),      32'(0));
    chk({tag, "_rstart"},    32'(round_start),  32'(0));
    chk({tag, "_pattern"},   32'(mole_pattern), 32'(0));
    chk({tag, "_score"},     32'(score),        32'(0));
    chk({tag, "_hit"},       32'(hit_event),    32'(0));
    chk({tag, "_game_over"}, 32'(game_over),    32'(0));
  endtask

  task automatic do_start();
    start_pulse      = 1'b1;
    exp_score        = 0;
    pool             = 8'hFF;
    sel_all_selected = 1'b0;
    tick();
    clear_pulses();
    chk("start_sel_req",   32'(sel_req),   32'(1));
    chk("start_game_over", 32'(game_over), 32'(0));
    chk("start_score",     32'(score),     32'(to_bcd(exp_score)));
  endtask

  // Entered in the cycle where sel_req is high; returns once the following REQ or OVER is visible.
  task automatic play_round(input bit force_hit, output bit over);
    int n;
    int kind;
    int wrong_cycles;
    bit all_sel;
    logic [7:0] tbit;
    logic [7:0] rel;
    tick();
    chk("wait_sel_req", 32'(sel_req), 32'(0));
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      mole_release  = 8'($urandom);
      round_timeout = 1'($urandom);
      start_pulse   = 1'($urandom);
      tick();
      clear_pulses();
      chk("wait_pattern", 32'(mole_pattern), 32'(0));
      chk("wait_score",   32'(score),        32'(to_bcd(exp_score)));
    end
    if (long_mode) begin
      n = int'($urandom % 8);
      long_left--;
      all_sel = (long_left <= 0);
    end else begin
      n = int'($urandom % 8);
      while (!pool[n]) n = (n + 1) % 8;
      pool[n] = 1'b0;
      all_sel = (pool == 8'h00);
    end
    tbit             = 8'd1 << n;
    sel_number       = 3'(n);
    sel_done         = 1'b1;
    sel_all_selected = all_sel;
    tick();
    clear_pulses();
    chk("show_pattern", 32'(mole_pattern), 32'(tbit));
    chk("show_rstart",  32'(round_start),  32'(1));
    wrong_cycles = force_hit ? 0 : int'($urandom_range(0, 4));
    for (int i = 0; i < wrong_cycles; i++) begin
      rel          = 8'($urandom) & ~tbit;
      mole_release = rel;
      start_pulse  = 1'($urandom);
      sel_done     = 1'($urandom);
      sel_number   = 3'($urandom);
`ifdef WHACK_MISS_PENALTY_EN
      if (rel != 8'h00 && exp_score > 0) exp_score--;
`endif
      tick();
      clear_pulses();
      chk("wrong_pattern", 32'(mole_pattern), 32'(tbit));
      chk("wrong_rstart",  32'(round_start),  32'(0));
      chk("wrong_hit",     32'(hit_event),    32'(0));
      chk("wrong_score",   32'(score),        32'(to_bcd(exp_score)));
    end
    kind = force_hit ? 0 : int'($urandom % 3);
    if (kind == 2) begin
      round_timeout = 1'b1;
    end else begin
      mole_release  = tbit | ((kind == 1) ? 8'($urandom) : 8'h00);
      round_timeout = (kind == 1);
      exp_score     = (exp_score + MULT > 9999) ? 9999 : exp_score + MULT;
    end
    tick();
    clear_pulses();
    chk("end_hit",     32'(hit_event),    32'(kind != 2));
    chk("end_pattern", 32'(mole_pattern), 32'(0));
    chk("end_score",   32'(score),        32'(to_bcd(exp_score)));
    tick();
    if (all_sel) begin
      chk("over_level",   32'(game_over), 32'(1));
      chk("over_sel_req", 32'(sel_req),   32'(0));
    end else begin
      chk("next_sel_req",   32'(sel_req),   32'(1));
      chk("next_game_over", 32'(game_over), 32'(0));
    end
    over = all_sel;
  endtask

  task automatic play_game();
    bit over = 1'b0;
    int guard = 0;
    while (!over && guard < 2000) begin
      play_round(long_mode, over);
      guard++;
    end
    chk("game_finished", 32'(over), 32'(1));
    for (int i = 0; i < 3; i++) begin
      mole_release  = 8'($urandom);
      round_timeout = 1'($urandom);
      sel_done      = 1'($urandom);
      tick();
      clear_pulses();
      chk("held_game_over", 32'(game_over),    32'(1));
      chk("held_score",     32'(score),        32'(to_bcd(exp_score)));
      chk("held_pattern",   32'(mole_pattern), 32'(0));
      chk("held_sel_req",   32'(sel_req),      32'(0));
    end
  endtask

  initial begin
    rst              = 1'b1;
    sel_number       = '0;
    sel_all_selected = 1'b0;
    long_mode        = 1'b0;
    long_left        = 0;
    exp_score        = 0;
    pool             = 8'hFF;
    clear_pulses();
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_sel_req", 32'(sel_req), 32'(0));

    do_start();
    play_game();
    do_start();
    play_game();

    long_mode = 1'b1;
    long_left = 1450;
    do_start();
    play_game();
    chk("saturated", 32'(score), 32'(16'h9999));
    long_mode = 1'b0;

    do_start();
    tick();
    sel_number = 3'd5;
    sel_done   = 1'b1;
    tick();
    clear_pulses();
    chk("mid_pattern", 32'(mole_pattern), 32'(8'h20));
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel_done      = 1'($urandom);
      round_timeout = 1'($urandom);
      mole_release  = 8'($urandom);
      tick();
      clear_pulses();
      chk_all_zero("post_rst");
    end
    do_start();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
